dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter PRIO_MODE, default 0: 0 = round-robin between ports, 1 = fixed priority with port 0 always winning.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0 / req1  input  1  request from port 0 / port 1; held high until ack.
REQ-005 we0 / we1  input  1  1 = write, 0 = read; held stable while req high.
REQ-006 addr0 / addr1  input  12  byte address; word index is addr[11:2]; held stable while req high.
REQ-007 wdata0 / wdata1  input  32  write data; held stable while req high.
REQ-008 ack0 / ack1  output  1  one-cycle completion pulse for the port.
REQ-009 rdata0 / rdata1  output  32  registered read data; valid in the ack cycle and held until the next completion on that port.
REQ-010 err0 / err1  output  1  misaligned-access flag; valid in the ack cycle only.
REQ-011 mem_addr  output  12  byte address to data memory.
REQ-012 mem_din  output  32  write data to data memory.
REQ-013 mem_we  output  1  write enable to data memory; memory commits on the rising edge while high.
REQ-014 mem_dout  input  32  combinational read data from data memory at mem_addr.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and DONE, with transitions IDLE->ACCESS (any req high), ACCESS->DONE (unconditional), DONE->IDLE (unconditional).
REQ-017 req0 and req1 SHALL be sampled only in IDLE; in IDLE with neither req high, the FSM SHALL stay in IDLE.
REQ-018 On leaving IDLE, the FSM SHALL latch the winner's id, we, addr and wdata into internal registers; later changes on the port inputs SHALL be ignored until DONE.
REQ-019 Single request: that port SHALL win.
REQ-020 Simultaneous requests with PRIO_MODE=0: the port not granted last SHALL win, and the last-grant pointer SHALL update on every grant.
REQ-021 Simultaneous requests with PRIO_MODE=1: port 0 SHALL always win.
REQ-022 In ACCESS, mem_addr SHALL equal the latched addr and mem_din SHALL equal the latched wdata.
REQ-023 In ACCESS, mem_we SHALL equal latched we AND (latched addr[1:0]==0) AND NOT rst.
REQ-024 Outside ACCESS, mem_addr, mem_din and mem_we SHALL be 0.
REQ-025 At the ACCESS->DONE edge, for an aligned read, the winner's rdata SHALL capture mem_dout.
REQ-026 At the ACCESS->DONE edge, for a misaligned access (read or write), the winner's rdata SHALL load 0.
REQ-027 At the ACCESS->DONE edge, for an aligned write, the winner's rdata SHALL be left unchanged.
REQ-028 The other port's rdata SHALL never change during a transaction it did not win.
REQ-029 In DONE, exactly the winner's ack SHALL be 1 for that single cycle.
REQ-030 In DONE, the winner's err SHALL be 1 if latched addr[1:0]!=0, else 0.
REQ-031 Latency: a req sampled high in IDLE at cycle N SHALL produce the winner's ack in cycle N+2; throughput SHALL be one transaction per 3 cycles.
REQ-032 A requester SHALL drop req, or present a new command, on the edge ending its ack cycle; a req still high in the following IDLE SHALL be treated as a new request.
REQ-033 A losing port's req SHALL remain pending and be granted in the next IDLE; with PRIO_MODE=0, no port SHALL wait more than one transaction.
REQ-034 ack and err SHALL be 0 in all cycles other than DONE.

Reset
REQ-035 When rst is high at a rising edge, the FSM SHALL go to IDLE.
REQ-036 When rst is high at a rising edge, ack0/1, err0/1 and rdata0/1 SHALL be 0.
REQ-037 When rst is high at a rising edge, the last-grant pointer SHALL be set so that port 0 wins the first contested round-robin grant.
REQ-038 Reset in ACCESS SHALL suppress the pending write (mem_we=0 that cycle) and SHALL produce no ack.
REQ-039 Reset in DONE SHALL clear the pending ack from the next cycle on.
REQ-040 busy SHALL be 0 in the cycle after reset.

Verification
REQ-041 Port 0 write addr=0x010, wdata=0xDEADBEEF, then port 0 read addr=0x010 -> write ack0 at N+2 with err0=0; read ack0 at N+2 with rdata0=0xDEADBEEF.
REQ-042 req0 and req1 both high from reset, PRIO_MODE=0, each re-requesting after its ack -> acks alternate ack0, ack1, ack0, ack1, one ack every 3 cycles.
REQ-043 The same stimulus as REQ-042 with PRIO_MODE=1 and req0 held continuously -> only ack0 is seen and port 1 is starved.
REQ-044 Port 1 write addr=0x013, wdata=0x12345678 -> ack1=1, err1=1, mem_we never 1, and a later aligned read of 0x010 returns the prior contents.
REQ-045 Port 0 write to 0x020 with rst asserted in the ACCESS cycle -> mem_we=0, no ack0, and a read of 0x020 after reset returns the pre-reset value.
REQ-046 Port 1 read completes with rdata1=0xA5A5A5A5, then port 0 transactions run -> rdata1 stays 0xA5A5A5A5 throughout.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter.
// Each transaction is IDLE -> ACCESS -> DONE: the request is sampled in IDLE,
// memory is driven in ACCESS, and the ack/err pulse goes out in DONE.
// PRIO_MODE selects round-robin (0) or fixed priority to port 0 (1).
module dmem_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [11:0] addr0,
    input  logic [11:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_we,
    input  logic [31:0] mem_dout,
    output logic        busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]  state;
    logic [1:0]  nextState;
    logic        anyReq;
    logic        grantPort;
    logic        startTxn;
    logic        lastGrant;   // id of the port granted most recently
    logic        curPort;
    logic        curWe;
    logic [11:0] curAddr;
    logic [31:0] curWdata;
    logic        curAligned;
    logic        inAccess;
    logic        inDone;

    assign anyReq     = req0 | req1;
    assign startTxn   = (state == IDLE) && anyReq;
    assign curAligned = (curAddr[1:0] == 2'b00);
    assign inAccess   = (state == ACCESS);
    assign inDone     = (state == DONE);

    // Pick the winner among the currently raised requests.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        grantPort = 1'b0;
        if (req0 && req1) begin
            grantPort = (PRIO_MODE == 1) ? 1'b0 : ~lastGrant;
        end else if (req1) begin
            grantPort = 1'b1;
        end
    end

    // Next-state logic: requests only matter in IDLE, the other two states always advance.
    always_comb begin
        nextState = IDLE;
        case (state)
            IDLE:    nextState = anyReq ? ACCESS : IDLE;
            ACCESS:  nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register and last-grant pointer; reset makes port 0 the first contested winner.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (rst) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
        end else begin
            state <= nextState;
            if (startTxn) begin
                lastGrant <= grantPort;
            end
        end
    end

    // Capture the winner's command when leaving IDLE; port inputs are ignored afterwards.
    always_ff @(posedge clk) begin
        // NOTE: the command register is not reset: it is only observed in ACCESS/DONE, which are always preceded by a load.
        if (startTxn) begin
            curPort  <= grantPort;
            curWe    <= grantPort ? we1    : we0;
            curAddr  <= grantPort ? addr1  : addr0;
            curWdata <= grantPort ? wdata1 : wdata0;
        end
    end

    // Read-data registers: only the winner's register moves, and only at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (inAccess) begin
            if (!curAligned) begin
                if (curPort) rdata1 <= '0;
                else         rdata0 <= '0;
            end else if (!curWe) begin
                if (curPort) rdata1 <= mem_dout;
                else         rdata0 <= mem_dout;
            end
        end
    end

    // Memory drive is zero outside ACCESS; a misaligned or reset-hit write never reaches memory.
    always_comb begin
        mem_addr = inAccess ? curAddr  : 12'd0;
        mem_din  = inAccess ? curWdata : 32'd0;
        mem_we   = inAccess && curWe && curAligned && !rst;
    end

    // Completion signalling comes straight from the DONE state.
    always_comb begin
        ack0 = inDone && !curPort;
        ack1 = inDone &&  curPort;
        err0 = ack0 && !curAligned;
        err1 = ack1 && !curAligned;
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin and a fixed-priority instance share
// the same port stimulus, each with its own behavioural data memory.
// Expected completions go into a per-instance scoreboard queue when a request
// is driven and are popped and compared whenever that instance acks.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [11:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;

    logic        ack0 [2];
    logic        ack1 [2];
    logic        err0 [2];
    logic        err1 [2];
    logic        busy [2];
    logic        memWe [2];
    logic [31:0] rdata0 [2];
    logic [31:0] rdata1 [2];
    logic [31:0] memDin [2];
    logic [31:0] memDout [2];
    logic [11:0] memAddr [2];

    logic [31:0] memA [1024];
    logic [31:0] memB [1024];
    logic        initMem;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        sb0 [$];
    exp_t        sb1 [$];
    logic [31:0] modelMem [1024];
    logic [31:0] modelRd [2][2];
    int          cyc;
    int          testCnt;
    int          failCnt;
    logic        ackSeen;

    dmem_arbiter #(.PRIO_MODE(0)) u_dut_rr (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0[0]), .ack1(ack1[0]), .rdata0(rdata0[0]), .rdata1(rdata1[0]),
        .err0(err0[0]), .err1(err1[0]),
        .mem_addr(memAddr[0]), .mem_din(memDin[0]), .mem_we(memWe[0]),
        .mem_dout(memDout[0]), .busy(busy[0])
    );

    dmem_arbiter #(.PRIO_MODE(1)) u_dut_fp (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0[1]), .ack1(ack1[1]), .rdata0(rdata0[1]), .rdata1(rdata1[1]),
        .err0(err0[1]), .err1(err1[1]),
        .mem_addr(memAddr[1]), .mem_din(memDin[1]), .mem_we(memWe[1]),
        .mem_dout(memDout[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    assign memDout[0] = memA[memAddr[0][11:2]];
    assign memDout[1] = memB[memAddr[1][11:2]];

    // Behavioural memories: combinational read, write committed on the rising edge.
    always @(posedge clk) begin
        if (initMem) begin
            for (int i = 0; i < 1024; i++) memA[i] <= initWord(i);
        end else if (memWe[0]) begin
            memA[memAddr[0][11:2]] <= memDin[0];
        end
    end

    always @(posedge clk) begin
        if (initMem) begin
            for (int i = 0; i < 1024; i++) memB[i] <= initWord(i);
        end else if (memWe[1]) begin
            memB[memAddr[1][11:2]] <= memDin[1];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        testCnt++;
        assert (obs === expv) else begin
            failCnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic pushExp(input int g, input logic port, input logic err,
                           input logic [31:0] rdata, input int due);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rdata;
        e.due   = due;
        if (g == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // On every ack, pop the oldest expectation and compare port, timing, err and both rdata ports.
    task automatic monitorInst(input int g);
        exp_t        e;
        logic        a0, a1, have;
        logic [31:0] rdWin, rdOther;
        a0 = ack0[g];
        a1 = ack1[g];
        if (a0 || a1) begin
            if (g == 0) ackSeen = 1'b1;
            check($sformatf("inst%0d ack exclusive", g), 32'(a0 & a1), 32'd0);
            have = 1'b0;
            if (g == 0) begin
                have = (sb0.size() > 0);
                if (have) e = sb0.pop_front();
            end else begin
                have = (sb1.size() > 0);
                if (have) e = sb1.pop_front();
            end
            check($sformatf("inst%0d ack expected", g), 32'(have), 32'd1);
            if (have) begin
                check($sformatf("inst%0d ack port", g), 32'(a1), 32'(e.port));
                check($sformatf("inst%0d ack cycle", g), 32'(cyc), 32'(e.due));
                check($sformatf("inst%0d err", g), 32'(a1 ? err1[g] : err0[g]), 32'(e.err));
                rdWin   = e.port ? rdata1[g] : rdata0[g];
                rdOther = e.port ? rdata0[g] : rdata1[g];
                check($sformatf("inst%0d rdata winner", g), rdWin, e.rdata);
                check($sformatf("inst%0d rdata other", g), rdOther, modelRd[g][~e.port]);
                modelRd[g][e.port] = e.rdata;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        monitorInst(0);
        monitorInst(1);
    endtask

    task automatic clearModelRd();
        for (int g = 0; g < 2; g++) begin
            modelRd[g][0] = '0;
            modelRd[g][1] = '0;
        end
    endtask

    // One uncontested transaction on a port, checked on both instances.
    task automatic doTxn(input logic port, input logic we, input logic [11:0] addr,
                         input logic [31:0] wdata);
        logic        aligned;
        int          idx;
        logic [31:0] rd;
        aligned = (addr[1:0] == 2'b00);
        idx     = int'(addr[11:2]);
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end
        for (int g = 0; g < 2; g++) begin
            if (!aligned)  rd = '0;
            else if (we)   rd = modelRd[g][port];
            else           rd = modelMem[idx];
            pushExp(g, port, !aligned, rd, cyc + 2);
        end
        if (we && aligned) modelMem[idx] = wdata;
        step();
        for (int g = 0; g < 2; g++) begin
            check($sformatf("inst%0d access mem_addr", g), 32'(memAddr[g]), 32'(addr));
            check($sformatf("inst%0d access mem_din", g), memDin[g], wdata);
            check($sformatf("inst%0d access mem_we", g), 32'(memWe[g]), 32'(we && aligned));
            check($sformatf("inst%0d access busy", g), 32'(busy[g]), 32'd1);
        end
        ackSeen = 1'b0;
        for (int i = 0; i < 6 && !ackSeen; i++) step();
        check("ack within budget", 32'(ackSeen), 32'd1);
        if (port) req1 = 1'b0;
        else      req0 = 1'b0;
        step();
    endtask

    initial begin
        int c0;
        testCnt = 0;
        failCnt = 0;
        cyc     = 0;
        ackSeen = 1'b0;
        initMem = 1'b1;
        rst     = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 1024; i++) modelMem[i] = initWord(i);
        clearModelRd();

        // Reset and the cycle right after it.
        step();
        step();
        initMem = 1'b0;
        rst     = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("inst%0d reset busy", g), 32'(busy[g]), 32'd0);
            check($sformatf("inst%0d reset ack0", g), 32'(ack0[g]), 32'd0);
            check($sformatf("inst%0d reset ack1", g), 32'(ack1[g]), 32'd0);
            check($sformatf("inst%0d reset rdata0", g), rdata0[g], 32'd0);
            check($sformatf("inst%0d reset rdata1", g), rdata1[g], 32'd0);
            check($sformatf("inst%0d reset mem_we", g), 32'(memWe[g]), 32'd0);
            check($sformatf("inst%0d reset mem_addr", g), 32'(memAddr[g]), 32'd0);
        end
        step();

        // Port 0 write then read back.
        doTxn(1'b0, 1'b1, 12'h010, 32'hDEADBEEF);
        doTxn(1'b0, 1'b0, 12'h010, 32'h0);

        // Port 1 misaligned write is dropped and flagged; the word keeps its contents.
        doTxn(1'b1, 1'b1, 12'h013, 32'h12345678);
        doTxn(1'b1, 1'b0, 12'h010, 32'h0);

        // Aligned write leaves rdata1 alone; then rdata1 holds its value across port 0 traffic.
        doTxn(1'b1, 1'b1, 12'h040, 32'hA5A5A5A5);
        doTxn(1'b1, 1'b0, 12'h040, 32'h0);
        doTxn(1'b0, 1'b1, 12'h080, 32'h11111111);
        doTxn(1'b0, 1'b0, 12'h080, 32'h0);
        doTxn(1'b0, 1'b0, 12'h081, 32'h0);
        doTxn(1'b0, 1'b1, 12'h084, 32'h22222222);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("inst%0d rdata1 held", g), rdata1[g], 32'hA5A5A5A5);
        end

        // Reset during ACCESS suppresses the write and the ack.
        req0 = 1'b1; we0 = 1'b1; addr0 = 12'h020; wdata0 = 32'hCAFEF00D;
        step();
        check("inst0 write pending before reset", 32'(memWe[0]), 32'd1);
        rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("inst%0d reset in access mem_we", g), 32'(memWe[g]), 32'd0);
        end
        step();
        rst  = 1'b0;
        req0 = 1'b0;
        clearModelRd();
        #1;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("inst%0d busy after reset", g), 32'(busy[g]), 32'd0);
            check($sformatf("inst%0d rdata0 after reset", g), rdata0[g], 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            for (int g = 0; g < 2; g++) begin
                check($sformatf("inst%0d no ack after reset", g), 32'(ack0[g]), 32'd0);
            end
        end
        doTxn(1'b0, 1'b0, 12'h020, 32'h0);

        // Both ports requesting continuously from reset.
        rst  = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 12'h040;
        step();
        rst = 1'b0;
        clearModelRd();
        #1;
        check("inst0 busy after contested reset", 32'(busy[0]), 32'd0);
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            pushExp(0, k[0], 1'b0, k[0] ? modelMem[16] : modelMem[4], c0 + 2 + 3 * k);
            pushExp(1, 1'b0, 1'b0, modelMem[4], c0 + 2 + 3 * k);
        end
        for (int i = 0; i < 11; i++) step();
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        check("inst0 scoreboard drained", 32'(sb0.size()), 32'd0);
        check("inst1 scoreboard drained", 32'(sb1.size()), 32'd0);
        check("inst1 port1 starved", rdata1[1], 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
